// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the counter-width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Number of bits needed to count 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_sub_full_sub1.sv
// One-bit full subtractor: d = x - y - bi, bo is the borrow out.
module full_sub1 (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  // Difference and borrow of a single bit position.
  always_comb begin
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Handshake: start is sampled only in IDLE; a, b, bin are captured on the
// accepting edge; busy is high in SHIFT and DONE; done is a one-cycle pulse
// and diff/bout/ovf stay valid from that cycle until the next accepted start.
// Optional feature macro: SERIAL_SUB_OVF_EN (signed overflow flag).
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d, bout_q, bout_d;
  logic             fs_d, fs_bo;
  logic             accept, last_shift;

  assign accept     = (state_q == ST_IDLE) && start;
  assign last_shift = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);

  full_sub1 u_fs (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .bi (br_q),
    .d  (fs_d),
    .bo (fs_bo)
  );

  // Next-state and datapath: capture on accept, shift one bit per SHIFT cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Result bits enter from the MSB side so diff is LSB-aligned after WIDTH shifts.
        diff_d = {fs_d, diff_q[WIDTH-1:1]};
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = fs_bo;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          bout_d  = fs_bo;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;

  // Capture operand sign bits on accept; evaluate overflow on the final shift.
  always_comb begin
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
    end
    if (last_shift) ovf_d = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
  end

  // Overflow registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub (WIDTH=4) with immediate-assertion checks.
module tb_serial_sub;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done, bout, ovf;
  logic [W-1:0] diff;
  logic [1:0]   dbg_state;

  int cmp_cnt = 0;
  int err_cnt = 0;

`ifdef SERIAL_SUB_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  serial_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one operation; checks latency, results, the single done pulse and hold.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input bit toggle, input bit hold, input string tag);
    int lat;
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < W + 3) begin
      if (toggle) begin
        a   = W'($urandom_range(0, 15));
        b   = W'($urandom_range(0, 15));
        bin = 1'($urandom_range(0, 1));
      end
      tick();
      lat++;
    end
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_lat"}, lat, W);
    check({tag, "_diff"}, {28'b0, diff}, {28'b0, ed});
    check({tag, "_bout"}, {31'b0, bout}, {31'b0, eb});
    check({tag, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
    tick();
    check({tag, "_done_clr"}, {31'b0, done}, 32'd0);
    check({tag, "_busy_clr"}, {31'b0, busy}, 32'd0);
    check({tag, "_diff_hold"}, {28'b0, diff}, {28'b0, ed});
    check({tag, "_bout_hold"}, {31'b0, bout}, {31'b0, eb});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_diff", {28'b0, diff}, 32'd0);
    check("rst_bout", {31'b0, bout}, 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);

    // 2 - 1 - 0 = 1
    run_op(4'b0010, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, "op1");
    // 5 - 13 - 1 = -9 -> 7, borrow
    run_op(4'b0101, 4'b1101, 1'b1, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b0, "op2");
    // 1 - 15 = -14 -> 2, borrow; inputs scrambled during SHIFT
    run_op(4'b0001, 4'b1111, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, "op3_tog");
    // 10 - 6 - 1 = 3 with start held high through SHIFT and DONE
    run_op(4'b1010, 4'b0110, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1, "op4_hold");
    // back-to-back start in the IDLE cycle after DONE: 3 - 5 = -2 -> 14, borrow
    run_op(4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, "op5_b2b");

    // reset in the 2nd SHIFT cycle
    a = 4'b0111; b = 4'b0001; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mid_busy_pre", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_busy", {31'b0, busy}, 32'd0);
    check("mid_done", {31'b0, done}, 32'd0);
    check("mid_diff", {28'b0, diff}, 32'd0);
    check("mid_bout", {31'b0, bout}, 32'd0);
    check("mid_ovf", {31'b0, ovf}, 32'd0);
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check("mid_no_done", {31'b0, done}, 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", {31'b0, busy}, 32'd0);
    // 9 - 4 - 1 = 4
    run_op(4'b1001, 4'b0100, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, "op6_after_rst");

    // signed overflow: 7 - (-1) = 8 ; then 3 - 1 = 2 no overflow
    run_op(4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, OVF_ON, 1'b0, 1'b0, "op7_ovf");
    run_op(4'b0011, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, "op8_noovf");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
